muskbus_line_writer: RTL and testbench

- Write-side counterpart to the line reader used by the instruction cache.
- Accepts one 64-byte cache line plus its address from a cache or eviction path, then transfers it to memory over the Muskbus request channel.
- Transfer is one address beat followed by eight 64-bit data beats, each beat held until acknowledged.
- Single outstanding line; the requester holds off while busy.

---
 rtl/muskbus_line_writer_if.sv | 29 ++
 rtl/muskbus_line_writer.sv | 125 ++++++++++++
 tb/tb_muskbus_line_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muskbus_line_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : muskbus_line_writer_if
// Description : Muskbus request-channel bundle used by the line writer.
//               master drives the request beat; slave (memory side)
//               returns the acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
interface muskbus_line_writer_if;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;

    modport master (
        output reqcyc,
        output req,
        output reqtag,
        input  reqack
    );

    modport slave (
        input  reqcyc,
        input  req,
        input  reqtag,
        output reqack
    );
endinterface
`default_nettype wire

// File: rtl/muskbus_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : muskbus_line_writer
// Description : Accepts one 64-byte line plus address and writes it to memory
//               over the Muskbus request channel: one address beat followed
//               by BEATS 64-bit data beats, each held until acknowledged.
//               Single outstanding line; requests while busy are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module muskbus_line_writer #(
    parameter logic [12:0] WRTAG = 13'h1000,
    parameter int          BEATS = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    muskbus_line_writer_if.master     bus,
    input  wire logic                 wrreqcyc,
    input  wire logic [63:0]          wraddr,
    input  wire logic [0:64*8-1]      wrdata,
    output logic                      wrbusy,
    output logic                      wrrespcyc
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Index of the final data beat; the counter stops here and never wraps.
    localparam logic [2:0] c_LAST_BEAT = 3'(BEATS - 1);

    // Low six address bits are masked so the line is always 64-byte aligned.
    localparam logic [63:0] c_LINE_MASK = ~64'h3F;

    logic [1:0]      r_state;
    logic [2:0]      r_cnt;
    logic [63:0]     r_addr;
    logic [0:64*8-1] r_data;

    logic            w_accept;
    logic [8:0]      w_word_base;

    assign w_accept    = (r_state == c_IDLE) && wrreqcyc;
    assign w_word_base = {r_cnt, 6'd0};

    // Transfer sequencing: state and beat counter, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 3'd0;
                    if (wrreqcyc) begin
                        r_state <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (bus.reqack) begin
                        r_state <= c_DATA;
                        r_cnt   <= 3'd0;
                    end
                end
                c_DATA: begin
                    if (bus.reqack) begin
                        if (r_cnt == c_LAST_BEAT) begin
                            r_state <= c_DONE;
                            r_cnt   <= 3'd0;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Capture the aligned address and line payload at acceptance only.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= wraddr & c_LINE_MASK;
            r_data <= wrdata;
        end
    end

    // Bus beat decode from registered state: idle/done present an empty bus.
    always_comb begin
        bus.reqcyc = 1'b0;
        bus.req    = 64'd0;
        bus.reqtag = 13'd0;
        case (r_state)
            c_ADDR: begin
                bus.reqcyc = 1'b1;
                bus.req    = r_addr;
                bus.reqtag = WRTAG;
            end
            c_DATA: begin
                bus.reqcyc = 1'b1;
                bus.req    = r_data[w_word_base +: 64];
                bus.reqtag = WRTAG;
            end
            default: begin
                bus.reqcyc = 1'b0;
                bus.req    = 64'd0;
                bus.reqtag = 13'd0;
            end
        endcase
    end

    // Requester status: busy covers the whole line including the done cycle.
    always_comb begin
        wrbusy    = (r_state != c_IDLE);
        wrrespcyc = (r_state == c_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_muskbus_line_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muskbus_line_writer
// Description : Scoreboard bench for muskbus_line_writer. Stimulus pushes the
//               expected beat sequence and timing window; a negedge monitor
//               compares every DUT output against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muskbus_line_writer;

    localparam logic [12:0] c_TAG_A = 13'h1000;
    localparam logic [12:0] c_TAG_B = 13'h1005;
    localparam int          c_SENT  = 32'h7fff_ffff;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            wrreqcyc = 1'b0;
    logic [63:0]     wraddr   = 64'd0;
    logic [0:511]    wrdata   = '0;
    logic            ack      = 1'b0;
    logic            wrbusy, wrrespcyc, busy2, resp2;

    int              cyc     = 0;
    int              n_chk   = 0;
    int              n_pass  = 0;
    int              busy_lo = c_SENT;
    int              done_e  = c_SENT;
    logic [63:0]     exp_beats[$];

    muskbus_line_writer_if bus1();
    muskbus_line_writer_if bus2();

    assign bus1.reqack = ack;
    assign bus2.reqack = ack;

    muskbus_line_writer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .wrreqcyc  (wrreqcyc),
        .wraddr    (wraddr),
        .wrdata    (wrdata),
        .wrbusy    (wrbusy),
        .wrrespcyc (wrrespcyc)
    );

    muskbus_line_writer #(.WRTAG(c_TAG_B)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus2),
        .wrreqcyc  (wrreqcyc),
        .wraddr    (wraddr),
        .wrdata    (wrdata),
        .wrbusy    (busy2),
        .wrrespcyc (resp2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: outputs observed here are those the DUT holds at edge cyc+1.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_req   = 64'd0;
    always @(negedge clk) begin
        int          e;
        logic        eb, er;
        logic [63:0] exp_w;
        e  = cyc + 1;
        eb = (e >= busy_lo) && (e <= done_e);
        er = (e == done_e);
        check("wrbusy",     wrbusy,      eb);
        check("wrrespcyc",  wrrespcyc,   er);
        check("reqcyc",     bus1.reqcyc, eb && !er);
        check("wrbusy_t2",  busy2,       eb);
        check("wrresp_t2",  resp2,       er);
        check("reqcyc_t2",  bus2.reqcyc, eb && !er);
        if (prev_stall && !reset) check("stall_hold", bus1.req, prev_req);
        if (bus1.reqcyc) check("reqtag", bus1.reqtag, c_TAG_A);
        if (bus2.reqcyc) check("reqtag_t2", bus2.reqtag, c_TAG_B);
        if (bus1.reqcyc && ack) begin
            if (exp_beats.size() == 0) begin
                n_chk++;
                $display("FAIL beat_extra: got req %h, expected no beat (cycle %0d)", bus1.req, cyc);
            end else begin
                exp_w = exp_beats.pop_front();
                check("beat_data",    bus1.req, exp_w);
                check("beat_data_t2", bus2.req, exp_w);
            end
        end
        prev_stall = bus1.reqcyc && !ack && !reset;
        prev_req   = bus1.req;
    end

    function automatic logic [0:511] rnd_line();
        logic [0:511] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Stall cycles inserted before beat b (b=0 address, b=1+k data word k).
    function automatic int stall_for(input int mode, input int b);
        if (mode == 1) return (b == 0) ? 3 : ((b == 6) ? 2 : 0);
        if (mode == 2) return $urandom_range(0, 2);
        return 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            wrreqcyc = 1'b0;
            ack      = 1'($urandom_range(0, 1));
        end
    endtask

    // One line: request issued now (accepted at next edge A); beats acked per
    // mode; optional ignored request at A+rej_k; optional reset once abort_at
    // beats have been acknowledged.
    task automatic do_line(input logic [63:0] addr, input logic [0:511] data,
                           input int mode, input int rej_k, input int abort_at);
        int a, k, acks, stall;
        a        = cyc + 1;
        wrreqcyc = 1'b1;
        wraddr   = addr;
        wrdata   = data;
        ack      = 1'($urandom_range(0, 1));
        busy_lo  = a + 1;
        done_e   = c_SENT;
        exp_beats.push_back({addr[63:6], 6'h0});
        for (int i = 0; i < 8; i++) exp_beats.push_back(data[64*i +: 64]);
        acks  = 0;
        k     = 0;
        stall = stall_for(mode, 0);
        while (acks < 9) begin
            @(posedge clk); #1;
            k++;
            wrreqcyc = (k == rej_k);
            if (k == rej_k) begin
                wraddr = {$urandom, $urandom};
                wrdata = rnd_line();
            end
            if (acks == abort_at) begin
                check("pre_rst_reqcyc", bus1.reqcyc, 1'b1);
                ack = 1'b1;
                #2 reset = 1'b1;
                exp_beats.delete();
                busy_lo = c_SENT;
                done_e  = c_SENT;
                #1;
                check("rst_reqcyc",    bus1.reqcyc, 1'b0);
                check("rst_wrbusy",    wrbusy,      1'b0);
                check("rst_wrrespcyc", wrrespcyc,   1'b0);
                check("rst_req",       bus1.req,    64'd0);
                @(posedge clk); #1;
                reset    = 1'b0;
                wrreqcyc = 1'b0;
                return;
            end
            if (stall > 0) begin
                ack = 1'b0;
                stall--;
            end else begin
                ack = 1'b1;
                acks++;
                if (acks < 9) stall = stall_for(mode, acks);
            end
            if (acks == 9) done_e = a + k + 1;
        end
        // Done cycle: a request here must be ignored, ack is don't-care.
        @(posedge clk); #1;
        wrreqcyc = 1'($urandom_range(0, 1));
        wraddr   = {$urandom, $urandom};
        ack      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        wrreqcyc = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:511] pat;
        for (int i = 0; i < 8; i++) pat[64*i +: 64] = 64'(i) * 64'h1111_1111_1111_1111;

        // Reset, idle, then an asynchronous mid-cycle reset pulse and long idle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(5);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("idle_rst_reqcyc",    bus1.reqcyc, 1'b0);
        check("idle_rst_wrbusy",    wrbusy,      1'b0);
        check("idle_rst_wrrespcyc", wrrespcyc,   1'b0);
        @(posedge clk); #1 reset = 1'b0;
        idle(20);

        // Single write, ack always high.
        do_line(64'h0000_1234_5678_9A7F, pat, 0, 0, -1);
        idle(2);

        // Backpressure on address beat and data word 5.
        do_line({$urandom, $urandom}, rnd_line(), 1, 0, -1);
        idle(2);

        // Busy rejection at T+4, then a back-to-back request at T+11.
        do_line({$urandom, $urandom}, rnd_line(), 0, 4, -1);
        do_line({$urandom, $urandom}, rnd_line(), 0, 0, -1);
        idle(2);

        // Reset while data word 3 is on the bus, then a clean write.
        do_line({$urandom, $urandom}, rnd_line(), 0, 0, 4);
        idle(3);
        do_line({$urandom, $urandom}, pat, 0, 0, -1);

        // Randomized lines with random stalls, gaps and ignored requests.
        repeat (12) begin
            idle($urandom_range(0, 3));
            do_line({$urandom, $urandom}, rnd_line(), 2, $urandom_range(1, 14), -1);
        end

        idle(5);
        check("queue_empty", 64'(exp_beats.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
